// File: rtl/icon_channel_arbiter_if.sv
// Interconnect broadcast-channel types and the requester/channel bundle.
// Requesters and the channel share one interface; the arbiter is master.
package pkg_dtypes;
  typedef logic [3:0]  type_exec_unit_addr;
  typedef logic [31:0] type_exec_unit_data;
  typedef struct packed {
    logic [7:0] eus;
    logic [3:0] receiver_str;
  } type_icon_receivers_list;
endpackage

interface icon_channel_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import pkg_dtypes::*;
  localparam int LOG2_NUM_REQ = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      i_req_valid;
  type_exec_unit_addr      i_req_src_addr [NUM_REQ];
  type_exec_unit_data      i_req_data [NUM_REQ];
  type_icon_receivers_list i_req_receivers [NUM_REQ];
  logic [NUM_REQ-1:0]      o_req_ack;
  type_exec_unit_addr      o_ch_src_addr;
  type_exec_unit_data      o_ch_data;
  logic                    o_ch_data_valid;
  type_icon_receivers_list o_ch_receiver_list;
  type_icon_receivers_list i_ch_success_list;
  logic                    o_busy;
  logic [LOG2_NUM_REQ-1:0] o_grant_idx;
  logic                    o_timeout;
  logic                    o_timeout_err;

  modport master (
    input  i_req_valid, i_req_src_addr, i_req_data,
    input  i_req_receivers, i_ch_success_list,
    output o_req_ack, o_ch_src_addr, o_ch_data,
    output o_ch_data_valid, o_ch_receiver_list,
    output o_busy, o_grant_idx, o_timeout, o_timeout_err
  );

  modport slave (
    output i_req_valid, i_req_src_addr, i_req_data,
    output i_req_receivers, i_ch_success_list,
    input  o_req_ack, o_ch_src_addr, o_ch_data,
    input  o_ch_data_valid, o_ch_receiver_list,
    input  o_busy, o_grant_idx, o_timeout, o_timeout_err
  );
endinterface

// File: rtl/icon_channel_arbiter.sv
// Round-robin owner of one interconnect broadcast channel.
// Holds a broadcast until all listed receivers accept, or the watchdog fires.
module icon_channel_arbiter
  import pkg_dtypes::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int LOG2_NUM_REQ   = $clog2(NUM_REQ)
) (
  input logic                    i_clk,
  input logic                    i_reset,
  icon_channel_arbiter_if.master bus
);
  localparam int RW = $bits(type_icon_receivers_list);
  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic {IDLE, BCAST} state_t;

  state_t                  state;
  logic [LOG2_NUM_REQ-1:0] rr_ptr;
  logic [LOG2_NUM_REQ-1:0] win_idx;
  logic [LOG2_NUM_REQ-1:0] probe;
  logic                    win_found;
  logic [NUM_REQ-1:0]      req_eff;
  logic [NUM_REQ-1:0]      grant_oh;
  logic [RW-1:0]           acc;
  logic [RW-1:0]           rx;
  logic [RW-1:0]           hit;
  logic [CW-1:0]           cnt;
  logic                    done;
  logic                    expire;

  assign rx       = bus.o_ch_receiver_list;
  assign hit      = (acc | bus.i_ch_success_list) & rx;
  assign done     = (hit == rx);
  assign expire   = (TIMEOUT_CYCLES > 0) &&
                    (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign grant_oh = NUM_REQ'(1) << bus.o_grant_idx;

  // The just-acked requester may still hold valid in its ack cycle.
  assign req_eff  = bus.i_req_valid &
                    ~((|bus.o_req_ack) ? grant_oh : '0);

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    probe     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      probe = LOG2_NUM_REQ'((int'(rr_ptr) + i) % NUM_REQ);
      if (!win_found && req_eff[probe]) begin
        win_found = 1'b1;
        win_idx   = probe;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state                  <= IDLE;
      rr_ptr                 <= LOG2_NUM_REQ'(NUM_REQ - 1);
      acc                    <= '0;
      cnt                    <= '0;
      bus.o_req_ack          <= '0;
      bus.o_ch_src_addr      <= '0;
      bus.o_ch_data          <= '0;
      bus.o_ch_data_valid    <= 1'b0;
      bus.o_ch_receiver_list <= '0;
      bus.o_busy             <= 1'b0;
      bus.o_grant_idx        <= '0;
      bus.o_timeout          <= 1'b0;
      bus.o_timeout_err      <= 1'b0;
    end else begin
      bus.o_req_ack <= '0;
      bus.o_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_found) begin
            state                  <= BCAST;
            rr_ptr                 <= win_idx;
            acc                    <= '0;
            cnt                    <= '0;
            bus.o_grant_idx        <= win_idx;
            bus.o_ch_src_addr      <= bus.i_req_src_addr[win_idx];
            bus.o_ch_data          <= bus.i_req_data[win_idx];
            bus.o_ch_receiver_list <= bus.i_req_receivers[win_idx];
            bus.o_ch_data_valid    <= 1'b1;
            bus.o_busy             <= 1'b1;
          end
        end
        BCAST: begin
          acc <= hit;
          if (done || expire) begin
            state               <= IDLE;
            bus.o_ch_data_valid <= 1'b0;
            bus.o_busy          <= 1'b0;
            bus.o_req_ack       <= grant_oh;
            // Completion in the final watchdog cycle still counts.
            if (!done) begin
              bus.o_timeout     <= 1'b1;
              bus.o_timeout_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_icon_channel_arbiter.sv
// Directed scoreboard bench for icon_channel_arbiter.
// Expected acks are queued at request time and popped when acks appear.
module tb_icon_channel_arbiter;
  import pkg_dtypes::*;

  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icon_channel_arbiter_if #(.NUM_REQ(N)) bus ();

  icon_channel_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus)
  );

  typedef struct {
    int          idx;
    bit          to;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic type_icon_receivers_list rl(
    input logic [7:0] e, input logic [3:0] s);
    type_icon_receivers_list r;
    r.eus          = e;
    r.receiver_str = s;
    return r;
  endfunction

  task automatic drive(input int i, input logic [3:0] src,
                       input logic [31:0] d, input logic [7:0] eus);
    bus.i_req_src_addr[i]  = src;
    bus.i_req_data[i]      = d;
    bus.i_req_receivers[i] = rl(eus, 4'h0);
  endtask

  task automatic push(input int idx, input bit to,
                      input logic [31:0] d);
    exp_t e;
    e.idx  = idx;
    e.to   = to;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_ack(input string tag);
    exp_t e;
    chk({tag, "_qsize"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_ack"}, 64'(bus.o_req_ack), 64'd1 << e.idx);
      chk({tag, "_gidx"}, 64'(bus.o_grant_idx), 64'(e.idx));
      chk({tag, "_tmo"}, 64'(bus.o_timeout), 64'(e.to));
      chk({tag, "_data"}, 64'(bus.o_ch_data), 64'(e.data));
    end
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int k = 0;
    do begin
      tick();
      k++;
    end while (bus.o_req_ack == '0 && k < budget);
    chk({tag, "_seen"}, 64'(|bus.o_req_ack), 64'd1);
    if (|bus.o_req_ack) pop_ack(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.i_req_valid       = '0;
    bus.i_ch_success_list = rl(8'h00, 4'h0);
    for (int i = 0; i < N; i++) drive(i, 4'h0, 32'h0, 8'h00);

    // reset state
    tick();
    tick();
    chk("rst_dv", 64'(bus.o_ch_data_valid), 64'd0);
    chk("rst_ack", 64'(bus.o_req_ack), 64'd0);
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_gidx", 64'(bus.o_grant_idx), 64'd0);
    chk("rst_tmo", 64'(bus.o_timeout), 64'd0);
    chk("rst_err", 64'(bus.o_timeout_err), 64'd0);
    chk("rst_data", 64'(bus.o_ch_data), 64'd0);
    chk("rst_rx", 64'(bus.o_ch_receiver_list), 64'd0);
    rst = 1'b0;
    tick();

    // single request, staggered receiver success
    drive(1, 4'h3, 32'hA5, 8'b0000_0011);
    bus.i_req_valid[1] = 1'b1;
    push(1, 1'b0, 32'hA5);
    tick();
    chk("t1_dv0", 64'(bus.o_ch_data_valid), 64'd1);
    chk("t1_busy", 64'(bus.o_busy), 64'd1);
    chk("t1_gidx", 64'(bus.o_grant_idx), 64'd1);
    chk("t1_src", 64'(bus.o_ch_src_addr), 64'h3);
    chk("t1_rx", 64'(bus.o_ch_receiver_list),
        64'(rl(8'b0000_0011, 4'h0)));
    bus.i_req_data[1] = 32'hFFFF;
    tick();
    chk("t1_dv1", 64'(bus.o_ch_data_valid), 64'd1);
    bus.i_ch_success_list = rl(8'b0000_0001, 4'h0);
    tick();
    chk("t1_dv2", 64'(bus.o_ch_data_valid), 64'd1);
    chk("t1_noack2", 64'(bus.o_req_ack), 64'd0);
    bus.i_ch_success_list = rl(8'h00, 4'h0);
    tick();
    chk("t1_dv3", 64'(bus.o_ch_data_valid), 64'd1);
    bus.i_ch_success_list = rl(8'b0000_0010, 4'h0);
    tick();
    pop_ack("t1");
    chk("t1_dv_end", 64'(bus.o_ch_data_valid), 64'd0);
    chk("t1_busy_end", 64'(bus.o_busy), 64'd0);
    bus.i_req_valid[1]    = 1'b0;
    bus.i_ch_success_list = rl(8'h00, 4'h0);
    tick();

    // all four requesting, round-robin order from requester 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++)
      drive(i, 4'(i), 32'h100 + i, 8'(1 << i));
    bus.i_req_valid       = '1;
    bus.i_ch_success_list = rl(8'hFF, 4'hF);
    push(0, 1'b0, 32'h100);
    push(1, 1'b0, 32'h101);
    push(2, 1'b0, 32'h102);
    push(3, 1'b0, 32'h103);
    push(0, 1'b0, 32'h100);
    for (int r = 0; r < 5; r++) wait_ack("t2", 4);
    bus.i_req_valid       = '0;
    bus.i_ch_success_list = rl(8'h00, 4'h0);
    tick();

    // empty receiver list completes in the first broadcast cycle
    bus.i_req_receivers[2] = rl(8'h00, 4'h0);
    bus.i_req_data[2]      = 32'h2222;
    bus.i_req_valid[2]     = 1'b1;
    push(2, 1'b0, 32'h2222);
    tick();
    chk("t3_dv", 64'(bus.o_ch_data_valid), 64'd1);
    tick();
    pop_ack("t3");
    chk("t3_dv_end", 64'(bus.o_ch_data_valid), 64'd0);
    bus.i_req_valid[2] = 1'b0;
    tick();
    chk("t3_ack_pulse", 64'(bus.o_req_ack), 64'd0);
    chk("t3_err", 64'(bus.o_timeout_err), 64'd0);

    // watchdog abort after TO broadcast cycles
    drive(0, 4'h5, 32'hDEAD, 8'b0000_0100);
    bus.i_req_valid[0] = 1'b1;
    push(0, 1'b1, 32'hDEAD);
    n = 0;
    tick();
    while (bus.o_ch_data_valid && bus.o_req_ack == '0 && n < 20) begin
      n++;
      tick();
    end
    chk("t4_bcast_cycles", 64'(n), 64'(TO));
    pop_ack("t4");
    chk("t4_err", 64'(bus.o_timeout_err), 64'd1);
    bus.i_req_valid[0] = 1'b0;
    tick();
    chk("t4_tmo_pulse", 64'(bus.o_timeout), 64'd0);
    chk("t4_err_sticky", 64'(bus.o_timeout_err), 64'd1);

    // success on unlisted bits is ignored
    drive(3, 4'h7, 32'h3333, 8'b0010_0000);
    bus.i_req_valid[3] = 1'b1;
    push(3, 1'b0, 32'h3333);
    tick();
    chk("t5_gidx", 64'(bus.o_grant_idx), 64'd3);
    bus.i_ch_success_list = rl(8'b1101_1111, 4'hF);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_noack", 64'(bus.o_req_ack), 64'd0);
    end
    bus.i_ch_success_list = rl(8'b0010_0000, 4'h0);
    tick();
    pop_ack("t5");
    bus.i_req_valid[3]    = 1'b0;
    bus.i_ch_success_list = rl(8'h00, 4'h0);
    tick();
    chk("t5_err_sticky", 64'(bus.o_timeout_err), 64'd1);

    // reset in the third broadcast cycle drops the broadcast
    drive(1, 4'h1, 32'h1111, 8'b0000_0001);
    bus.i_req_valid[1] = 1'b1;
    tick();
    chk("t6_gidx", 64'(bus.o_grant_idx), 64'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t6_rst_dv", 64'(bus.o_ch_data_valid), 64'd0);
    chk("t6_rst_ack", 64'(bus.o_req_ack), 64'd0);
    chk("t6_rst_busy", 64'(bus.o_busy), 64'd0);
    chk("t6_rst_gidx", 64'(bus.o_grant_idx), 64'd0);
    chk("t6_rst_err", 64'(bus.o_timeout_err), 64'd0);
    chk("t6_rst_data", 64'(bus.o_ch_data), 64'd0);
    bus.i_req_valid[1] = 1'b0;
    drive(0, 4'h8, 32'hAAAA, 8'b0000_0001);
    drive(3, 4'h9, 32'hBBBB, 8'b0000_0010);
    bus.i_req_valid[0] = 1'b1;
    bus.i_req_valid[3] = 1'b1;
    push(0, 1'b0, 32'hAAAA);
    push(3, 1'b0, 32'hBBBB);
    tick();
    chk("t6_hold_ack", 64'(bus.o_req_ack), 64'd0);
    rst = 1'b0;
    tick();
    chk("t6_first_gidx", 64'(bus.o_grant_idx), 64'd0);
    chk("t6_first_dv", 64'(bus.o_ch_data_valid), 64'd1);
    bus.i_ch_success_list = rl(8'hFF, 4'hF);
    wait_ack("t6a", 4);
    bus.i_req_valid[0] = 1'b0;
    wait_ack("t6b", 4);
    bus.i_req_valid       = '0;
    bus.i_ch_success_list = rl(8'h00, 4'h0);
    tick();
    chk("t6_qempty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
